// File: rtl/xadc_pkg.sv
`default_nettype none
// ============================================================================
// xadc_pkg : shared FSM encoding, DRP address constants and result width
// Revision : 1.0
// ============================================================================
package xadc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_e;

    localparam int RES_W        = 12;
    localparam int AUX_BASE_DEF = 16;

    localparam logic [6:0] CFG_REG0_ADDR = 7'h40;
    localparam logic [6:0] CFG_REG1_ADDR = 7'h41;
    localparam logic [6:0] CFG_REG2_ADDR = 7'h42;

    // Status registers for channels 0..31 sit at DRP addresses 0x00..0x1F.
    function automatic logic [6:0] chan_addr(input logic [4:0] ch);
        return {2'b00, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xadc_result_bank.sv
`default_nettype none
// ============================================================================
// xadc_result_bank : NUM_CH x 12-bit result register file, flattened read
// Revision : 1.0
// ============================================================================
module xadc_result_bank
    import xadc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [SLOT_W-1:0]         slot_i,
    input  logic [RES_W-1:0]          data_i,
    output logic [RES_W*NUM_CH-1:0]   bank_o
);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            logic [RES_W-1:0] slot_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    slot_q <= '0;
                end else if (we_i && (slot_i == SLOT_W'(k))) begin
                    slot_q <= data_i;
                end
            end

            assign bank_o[RES_W*k +: RES_W] = slot_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/xadc_drp_sequencer.sv
`default_nettype none
// ============================================================================
// xadc_drp_sequencer : reads each converted XADC channel over DRP into a
//                      result bank, sharing the port with config writes
// Revision : 1.0
// ============================================================================
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int AUX_BASE = AUX_BASE_DEF,
    parameter int TIMEOUT  = 63
) (
    input  logic                    dclk_in,
    input  logic                    reset_in,
    input  logic                    eoc_in,
    input  logic [4:0]              channel_in,
    output logic [6:0]              daddr_out,
    output logic                    den_out,
    output logic                    dwe_out,
    output logic [15:0]             di_out,
    input  logic [15:0]             do_in,
    input  logic                    drdy_in,
    input  logic                    cfg_req,
    input  logic [6:0]              cfg_addr,
    input  logic [15:0]             cfg_data,
    output logic                    cfg_ack,
    output logic                    sample_valid,
    output logic [4:0]              sample_chan,
    output logic [RES_W-1:0]        sample_data,
    output logic [RES_W*NUM_CH-1:0] bank_data,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q;
    logic             pend_q;
    logic [4:0]       pend_ch_q;
    logic [4:0]       rd_ch_q;
    logic [CNT_W-1:0] cnt_q;
    logic             den_q;
    logic             dwe_q;
    logic [6:0]       daddr_q;
    logic [15:0]      di_q;
    logic             cfg_ack_q;
    logic             cap_q;
    logic             sample_valid_q;
    logic [4:0]       sample_chan_q;
    logic [RES_W-1:0] sample_data_q;
    logic             overrun_q;
    logic             timeout_err_q;

    logic             w_rd_go;
    logic [4:0]       w_rd_ch;
    logic             w_cnt_done;
    logic             w_in_range;
    logic [SLOT_W-1:0] w_slot;
    logic             w_unused_do;

    // An eoc in an idle cycle is served directly so den follows one cycle later.
    assign w_rd_go    = pend_q | eoc_in;
    assign w_rd_ch    = pend_q ? pend_ch_q : channel_in;
    assign w_cnt_done = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign w_in_range = (int'(sample_chan_q) >= AUX_BASE) &&
                        (int'(sample_chan_q) <  AUX_BASE + NUM_CH);
    assign w_slot     = SLOT_W'(int'(sample_chan_q) - AUX_BASE);
    assign w_unused_do = &{1'b0, do_in[3:0]};

    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q        <= ST_IDLE;
            pend_q         <= 1'b0;
            pend_ch_q      <= '0;
            rd_ch_q        <= '0;
            cnt_q          <= '0;
            den_q          <= 1'b0;
            dwe_q          <= 1'b0;
            daddr_q        <= '0;
            di_q           <= '0;
            cfg_ack_q      <= 1'b0;
            cap_q          <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_chan_q  <= '0;
            sample_data_q  <= '0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            den_q          <= 1'b0;
            dwe_q          <= 1'b0;
            cfg_ack_q      <= 1'b0;
            cap_q          <= 1'b0;
            sample_valid_q <= cap_q;

            if (eoc_in) begin
                pend_q    <= 1'b1;
                pend_ch_q <= channel_in;
                if ((state_q != ST_IDLE) && (pend_q || (state_q == ST_RD_WAIT))) begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_rd_go) begin
                        den_q   <= 1'b1;
                        daddr_q <= chan_addr(w_rd_ch);
                        rd_ch_q <= w_rd_ch;
                        cnt_q   <= '0;
                        state_q <= ST_RD_WAIT;
                        // A stored request plus a fresh eoc leaves pend re-armed.
                        if (!(pend_q && eoc_in)) begin
                            pend_q <= 1'b0;
                        end
                    end else if (cfg_req) begin
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        daddr_q <= cfg_addr;
                        di_q    <= cfg_data;
                        cnt_q   <= '0;
                        state_q <= ST_WR_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (drdy_in) begin
                        sample_data_q <= do_in[15:4];
                        sample_chan_q <= rd_ch_q;
                        cap_q         <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (w_cnt_done) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (drdy_in || w_cnt_done) begin
                        cfg_ack_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        if (!drdy_in) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The bank is written on the same edge that raises sample_valid.
    xadc_result_bank #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_bank (
        .clk_i  (dclk_in),
        .rst_i  (reset_in),
        .we_i   (cap_q && w_in_range),
        .slot_i (w_slot),
        .data_i (sample_data_q),
        .bank_o (bank_data)
    );

    assign daddr_out    = daddr_q;
    assign den_out      = den_q;
    assign dwe_out      = dwe_q;
    assign di_out       = di_q;
    assign cfg_ack      = cfg_ack_q;
    assign sample_valid = sample_valid_q;
    assign sample_chan  = sample_chan_q;
    assign sample_data  = sample_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_sequencer.sv
`default_nettype none
// ============================================================================
// tb_xadc_drp_sequencer : scoreboard bench with a simple DRP responder model
// Revision : 1.0
// ============================================================================
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eoc_in = 1'b0;
    logic [4:0]  channel_in = '0;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in = '0;
    logic        drdy_in = 1'b0;
    logic        cfg_req = 1'b0;
    logic [6:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ack;
    logic        sample_valid;
    logic [4:0]  sample_chan;
    logic [11:0] sample_data;
    logic [47:0] bank_data;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    typedef struct packed { logic [6:0] addr; logic we; logic [15:0] di; } drp_t;
    typedef struct packed { logic [4:0] ch; logic [11:0] data; } smp_t;

    drp_t exp_drp[$];
    smp_t exp_smp[$];
    int   exp_acks = 0;
    int   checks   = 0;
    int   failures = 0;

    logic        resp_en    = 1'b1;
    int          resp_delay = 3;
    logic [15:0] resp_data  = '0;
    logic [47:0] exp_bank   = '0;

    xadc_drp_sequencer dut (
        .dclk_in      (clk),
        .reset_in     (rst),
        .eoc_in       (eoc_in),
        .channel_in   (channel_in),
        .daddr_out    (daddr_out),
        .den_out      (den_out),
        .dwe_out      (dwe_out),
        .di_out       (di_out),
        .do_in        (do_in),
        .drdy_in      (drdy_in),
        .cfg_req      (cfg_req),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ack      (cfg_ack),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .bank_data    (bank_data),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // DRP responder: drdy one cycle, resp_delay cycles after each den.
    always begin
        @(negedge clk);
        if (den_out && resp_en) begin
            repeat (resp_delay) @(negedge clk);
            do_in   = resp_data;
            drdy_in = 1'b1;
            @(negedge clk);
            drdy_in = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        drp_t d;
        smp_t s;
        if (!rst) begin
            if (den_out) begin
                checks++;
                if (exp_drp.size() == 0) begin
                    failures++;
                    $display("FAIL drp_unexpected actual addr=%h we=%b required none", daddr_out, dwe_out);
                end else begin
                    d = exp_drp.pop_front();
                    if (daddr_out !== d.addr || dwe_out !== d.we || (d.we && di_out !== d.di)) begin
                        failures++;
                        $display("FAIL drp_req actual addr=%h we=%b di=%h required addr=%h we=%b di=%h",
                                 daddr_out, dwe_out, di_out, d.addr, d.we, d.di);
                    end
                end
            end
            if (sample_valid) begin
                checks++;
                if (exp_smp.size() == 0) begin
                    failures++;
                    $display("FAIL sample_unexpected actual ch=%0d data=%h required none", sample_chan, sample_data);
                end else begin
                    s = exp_smp.pop_front();
                    if (sample_chan !== s.ch || sample_data !== s.data) begin
                        failures++;
                        $display("FAIL sample actual ch=%0d data=%h required ch=%0d data=%h",
                                 sample_chan, sample_data, s.ch, s.data);
                    end
                end
            end
            if (cfg_ack) begin
                checks++;
                if (exp_acks == 0) begin
                    failures++;
                    $display("FAIL ack_unexpected actual 1 required 0");
                end else begin
                    exp_acks--;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic pulse_eoc(input logic [4:0] ch);
        eoc_in     = 1'b1;
        channel_in = ch;
        tick();
        eoc_in     = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_drp.size() != 0 || exp_smp.size() != 0 || exp_acks != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        tick(3);
        chk({name, "_drain"}, 64'(exp_drp.size() + exp_smp.size() + exp_acks), 64'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_den"},   64'(den_out),      64'd0);
        chk({name, "_dwe"},   64'(dwe_out),      64'd0);
        chk({name, "_daddr"}, 64'(daddr_out),    64'd0);
        chk({name, "_di"},    64'(di_out),       64'd0);
        chk({name, "_ack"},   64'(cfg_ack),      64'd0);
        chk({name, "_sv"},    64'(sample_valid), 64'd0);
        chk({name, "_sch"},   64'(sample_chan),  64'd0);
        chk({name, "_sdat"},  64'(sample_data),  64'd0);
        chk({name, "_bank"},  64'(bank_data),    64'd0);
        chk({name, "_busy"},  64'(busy),         64'd0);
        chk({name, "_ovr"},   64'(overrun),      64'd0);
        chk({name, "_tmo"},   64'(timeout_err),  64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Single read of channel 16 into slot 0
        resp_delay = 3;
        resp_data  = 16'hABC0;
        exp_drp.push_back('{7'h10, 1'b0, 16'h0});
        exp_smp.push_back('{5'd16, 12'hABC});
        pulse_eoc(5'd16);
        chk("read_den_latency", 64'(den_out), 64'd1);
        drain("read");
        exp_bank[11:0] = 12'hABC;
        chk("read_bank", 64'(bank_data), 64'(exp_bank));

        // Read beats config write in the same cycle
        resp_data = 16'h5550;
        exp_drp.push_back('{7'h11, 1'b0, 16'h0});
        exp_drp.push_back('{7'h41, 1'b1, 16'h2000});
        exp_smp.push_back('{5'd17, 12'h555});
        exp_acks = 1;
        cfg_req  = 1'b1;
        cfg_addr = 7'h41;
        cfg_data = 16'h2000;
        pulse_eoc(5'd17);
        begin
            int n = 0;
            while (!cfg_ack && n < 60) begin
                tick();
                n++;
            end
            chk("arb_ack_seen", 64'(cfg_ack), 64'd1);
            cfg_req = 1'b0;
        end
        drain("arb");
        exp_bank[23:12] = 12'h555;
        chk("arb_bank", 64'(bank_data), 64'(exp_bank));
        chk("arb_dwe_low", 64'(dwe_out), 64'd0);

        // Overrun: 18 then 19 while 17 is in flight; 18 is dropped
        resp_delay = 6;
        resp_data  = 16'h7770;
        exp_drp.push_back('{7'h11, 1'b0, 16'h0});
        exp_drp.push_back('{7'h13, 1'b0, 16'h0});
        exp_smp.push_back('{5'd17, 12'h777});
        exp_smp.push_back('{5'd19, 12'h777});
        pulse_eoc(5'd17);
        pulse_eoc(5'd18);
        pulse_eoc(5'd19);
        chk("ovr_flag", 64'(overrun), 64'd1);
        drain("ovr");
        exp_bank[23:12] = 12'h777;
        exp_bank[47:36] = 12'h777;
        chk("ovr_bank", 64'(bank_data), 64'(exp_bank));

        // Out-of-range channel updates sample outputs only
        resp_delay = 3;
        resp_data  = 16'h1230;
        exp_drp.push_back('{7'h03, 1'b0, 16'h0});
        exp_smp.push_back('{5'd3, 12'h123});
        pulse_eoc(5'd3);
        drain("oor");
        chk("oor_bank", 64'(bank_data), 64'(exp_bank));

        // Timeout with no drdy, then a normal read
        resp_en = 1'b0;
        exp_drp.push_back('{7'h10, 1'b0, 16'h0});
        pulse_eoc(5'd16);
        tick(50);
        chk("tmo_not_yet", 64'(timeout_err), 64'd0);
        chk("tmo_busy_wait", 64'(busy), 64'd1);
        begin
            int n = 0;
            while (!timeout_err && n < 30) begin
                tick();
                n++;
            end
        end
        chk("tmo_flag", 64'(timeout_err), 64'd1);
        chk("tmo_busy_low", 64'(busy), 64'd0);
        tick(3);
        resp_en   = 1'b1;
        resp_data = 16'h0FF0;
        exp_drp.push_back('{7'h12, 1'b0, 16'h0});
        exp_smp.push_back('{5'd18, 12'h0FF});
        pulse_eoc(5'd18);
        drain("tmo_next");
        exp_bank[35:24] = 12'h0FF;
        chk("tmo_next_bank", 64'(bank_data), 64'(exp_bank));

        // Reset mid-read; late drdy must be ignored
        resp_delay = 6;
        resp_data  = 16'hDEA0;
        exp_drp.push_back('{7'h10, 1'b0, 16'h0});
        pulse_eoc(5'd16);
        tick();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        exp_bank = '0;
        chk_all_zero("midrst");
        chk("midrst_queues", 64'(exp_drp.size() + exp_smp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
